// File: rtl/spi_rx_buffer.sv
// ---------------------------------------------------------------------------
// spi_rx_buffer
//   Receive-side buffer that sits directly after the SPI slave. Each rising
//   edge of the slave's done flag captures one dout word into a small
//   first-word-fall-through FIFO. The consumer drains the FIFO over a
//   valid/ready handshake. A frame that arrives while the FIFO is full, with
//   no pop in the same cycle, is dropped and raises a sticky overflow flag.
//
// Ports
//   clk       system clock
//   rst       asynchronous reset, active low
//   done      slave frame-complete flag (may stay high for many cycles)
//   dout      slave received word, stable while done is high
//   rd_valid  rd_data holds the oldest stored word
//   rd_ready  consumer accepts the word when rd_valid && rd_ready
//   rd_data   head-of-FIFO word (reads as zero while empty)
//   level     number of stored words, 0..DEPTH
//   full      level == DEPTH
//   overflow  sticky: a frame was dropped because the FIFO was full
//   ovf_clr   synchronous clear of overflow (a same-cycle set wins)
// ---------------------------------------------------------------------------
module spi_rx_buffer #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       done,
  input  logic [WIDTH-1:0]           dout,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       overflow,
  input  logic                       ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic             done_q;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] mem [DEPTH];

  logic push;
  logic pop;
  logic wr_en;
  logic drop;

  // One push per done pulse, however long done stays high.
  assign push = done & ~done_q;
  assign pop  = rd_valid & rd_ready;

  // A pop in the same cycle frees the slot, so a push onto a full FIFO is
  // still accepted when the consumer is taking the head word.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  assign rd_valid = (count != '0);
  assign full     = (count == FULL_LEVEL);
  assign level    = count;

  // Gating keeps rd_data at zero in reset and stable while empty, since the
  // storage itself is never cleared.
  assign rd_data = rd_valid ? mem[rd_ptr] : '0;

  // NOTE: storage has no reset; the pointers and count alone define which
  // entries are valid, and a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= dout;
  end

  // NOTE: all state registers use non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q   <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      done_q <= done;

      // Pointers wrap naturally because DEPTH is a power of two.
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);

      unique case ({wr_en, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      if (drop)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_rx_buffer.sv
// ---------------------------------------------------------------------------
// tb_spi_rx_buffer
//   Self-checking bench for spi_rx_buffer. A queue-based reference model of
//   the buffer runs alongside the DUT; a compare process checks every output
//   against it on each falling clock edge. Directed scenarios add literal
//   expectations for latency, ordering, overflow, backpressure and reset,
//   followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_spi_rx_buffer;

  localparam int WIDTH = 12;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic             clk;
  logic             rst;
  logic             done;
  logic [WIDTH-1:0] dout;
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic [AW:0]      level;
  logic             full;
  logic             overflow;
  logic             ovf_clr;

  int checks = 0;
  int errors = 0;

  spi_rx_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .done     (done),
    .dout     (dout),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .level    (level),
    .full     (full),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [WIDTH-1:0] m_q[$];
  bit               m_ovf;
  bit               m_done_q;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_ovf    = 1'b0;
      m_done_q = 1'b0;
    end else begin
      bit frame, take, dropped;
      frame   = done && !m_done_q;
      take    = (m_q.size() != 0) && rd_ready;
      dropped = 1'b0;
      if (take) void'(m_q.pop_front());
      if (frame) begin
        if (m_q.size() < DEPTH) m_q.push_back(dout);
        else                    dropped = 1'b1;
      end
      if (dropped)      m_ovf = 1'b1;
      else if (ovf_clr) m_ovf = 1'b0;
      m_done_q = done;
    end
  end

  // Words actually handed to the consumer by the DUT, in order.
  logic [WIDTH-1:0] dut_out[$];

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("rd_valid", rd_valid, (m_q.size() != 0));
    check("level", level, m_q.size());
    check("full", full, (m_q.size() == DEPTH));
    check("overflow", overflow, m_ovf);
    if (m_q.size() != 0) check("rd_data", rd_data, m_q[0]);
    if (rd_valid && rd_ready) dut_out.push_back(rd_data);
  end

  // ---------------- stimulus helpers ----------------
  task automatic frame(input logic [WIDTH-1:0] w, input int hold);
    @(posedge clk); #1;
    done = 1'b1;
    dout = w;
    repeat (hold) @(posedge clk);
    #1 done = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] exp_w[$];
  logic [WIDTH-1:0] held;
  logic             pat[4];

  initial begin
    rst      = 1'b0;
    done     = 1'b0;
    dout     = '0;
    rd_ready = 1'b0;
    ovf_clr  = 1'b0;

    // Reset state
    #2;
    check("reset rd_valid", rd_valid, 0);
    check("reset level", level, 0);
    check("reset full", full, 0);
    check("reset overflow", overflow, 0);
    check("reset rd_data", rd_data, 0);
    #10 rst = 1'b1;
    idle(2);

    // T1: single long done pulse -> one word
    dut_out.delete();
    @(posedge clk); #1;
    done = 1'b1;
    dout = 12'hA5C;
    check("t1 not yet valid", rd_valid, 0);
    @(posedge clk); #1;
    check("t1 valid after push edge", rd_valid, 1);
    check("t1 data", rd_data, 12'hA5C);
    check("t1 level", level, 1);
    repeat (21) @(posedge clk);
    #1 done = 1'b0;
    check("t1 single push", level, 1);
    rd_ready = 1'b1;
    idle(1);
    check("t1 drained", level, 0);
    rd_ready = 1'b0;
    check("t1 count", dut_out.size(), 1);
    if (dut_out.size() == 1) check("t1 word", dut_out[0], 12'hA5C);

    // T2: 20 frames with consumer always ready
    dut_out.delete();
    rd_ready = 1'b1;
    for (int i = 1; i <= 20; i++) frame(WIDTH'(i), 1 + $urandom_range(0, 2));
    idle(4);
    check("t2 count", dut_out.size(), 20);
    for (int i = 0; i < 20 && i < dut_out.size(); i++) check("t2 order", dut_out[i], i + 1);
    check("t2 no overflow", overflow, 0);

    // T3: nine frames into an eight-entry FIFO
    dut_out.delete();
    exp_w.delete();
    rd_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      logic [WIDTH-1:0] w;
      w = WIDTH'($urandom);
      if (i < 8) exp_w.push_back(w);
      frame(w, 1);
      if (i == 7) begin
        check("t3 full after 8", full, 1);
        check("t3 no ovf after 8", overflow, 0);
      end
    end
    check("t3 level", level, 8);
    check("t3 overflow", overflow, 1);
    rd_ready = 1'b1;
    idle(10);
    rd_ready = 1'b0;
    check("t3 drain count", dut_out.size(), 8);
    for (int i = 0; i < 8 && i < dut_out.size(); i++) check("t3 drain word", dut_out[i], exp_w[i]);
    check("t3 ovf still set", overflow, 1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    check("t3 ovf cleared", overflow, 0);

    // T4: push onto a full FIFO with a simultaneous pop
    dut_out.delete();
    for (int i = 0; i < 8; i++) frame(12'h100 + WIDTH'(i), 1);
    check("t4 full", full, 1);
    @(posedge clk); #1;
    done     = 1'b1;
    dout     = 12'h7E7;
    rd_ready = 1'b1;
    idle(1);
    rd_ready = 1'b0;
    done     = 1'b0;
    check("t4 level stays 8", level, 8);
    check("t4 no overflow", overflow, 0);
    rd_ready = 1'b1;
    idle(10);
    rd_ready = 1'b0;
    check("t4 drain count", dut_out.size(), 9);
    for (int i = 0; i < 8 && i < dut_out.size(); i++) check("t4 drain word", dut_out[i], 12'h100 + i);
    if (dut_out.size() == 9) check("t4 new word last", dut_out[8], 12'h7E7);

    // T5: backpressure 1,0,0,1 on three stored words
    dut_out.delete();
    exp_w.delete();
    for (int i = 0; i < 3; i++) begin
      logic [WIDTH-1:0] w;
      w = WIDTH'($urandom);
      exp_w.push_back(w);
      frame(w, 1);
    end
    idle(1);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int k = 0; k < 4; k++) begin
      rd_ready = pat[k];
      held = rd_data;
      idle(1);
      if (!pat[k]) begin
        check("t5 hold valid", rd_valid, 1);
        check("t5 hold data", rd_data, held);
      end
    end
    rd_ready = 1'b1;
    idle(3);
    rd_ready = 1'b0;
    check("t5 count", dut_out.size(), 3);
    for (int i = 0; i < 3 && i < dut_out.size(); i++) check("t5 order", dut_out[i], exp_w[i]);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) done = ~done;
      if (!done) dout = WIDTH'($urandom);
      rd_ready = ($urandom_range(0, 2) == 0);
      ovf_clr  = ($urandom_range(0, 15) == 0);
    end
    done     = 1'b0;
    ovf_clr  = 1'b0;
    rd_ready = 1'b1;
    idle(12);
    rd_ready = 1'b0;

    // T6: asynchronous reset with words stored
    for (int i = 0; i < 4; i++) frame(WIDTH'($urandom), 1);
    check("t6 level before", level, 4);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6 rd_valid", rd_valid, 0);
    check("t6 level", level, 0);
    check("t6 overflow", overflow, 0);
    check("t6 full", full, 0);
    dut_out.delete();
    @(posedge clk);
    #2 rst = 1'b1;
    frame(12'h3C3, 2);
    rd_ready = 1'b1;
    idle(4);
    rd_ready = 1'b0;
    check("t6 count", dut_out.size(), 1);
    if (dut_out.size() == 1) check("t6 word", dut_out[0], 12'h3C3);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
